sc_mult_sequencer: RTL and testbench

SC_MULT_SEQUENCER -- requirements
Module: sc_mult_sequencer

---
 rtl/sc_pkg.sv | 31 +++
 rtl/sc_lfsr31.sv | 26 ++
 rtl/sc_mult_sequencer.sv | 159 +++++++++++++++
 tb/tb_sc_mult_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and constants for the stochastic multiply sequencer
package sc_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_LO = 27;
  localparam int TAP_HI = 30;
  localparam int LEN_W  = 9;

  localparam logic [2:0]        LEN_SEL_MAX = 3'd5;
  localparam logic [LEN_W-1:0]  LEN_BASE    = 9'd8;
  localparam logic [LEN_W-1:0]  LEN_MAX     = 9'd256;

  localparam logic [LFSR_W-1:0] DEF_SEED_A = 31'd1;
  localparam logic [LFSR_W-1:0] DEF_SEED_B = 31'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_t;

  // Stream length N = 8 << sel; codes above 5 saturate at 256.
  function automatic logic [LEN_W-1:0] len_decode(input logic [2:0] sel);
    if (sel > LEN_SEL_MAX) begin
      return LEN_MAX;
    end
    return LEN_BASE << sel;
  endfunction

endpackage

// File: rtl/sc_lfsr31.sv
// rtl/sc_lfsr31.sv - 31-bit Fibonacci LFSR with synchronous seed load
import sc_pkg::*;

module sc_lfsr31 #(
  parameter logic [LFSR_W-1:0] RST_VAL = DEF_SEED_A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  // Load wins over step; feedback is the XOR of taps 27 and 30 shifted in at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= {q[LFSR_W-2:0], q[TAP_LO] ^ q[TAP_HI]};
    end
  end

endmodule

// File: rtl/sc_mult_sequencer.sv
// rtl/sc_mult_sequencer.sv - stochastic-computing multiply job sequencer
import sc_pkg::*;

module sc_mult_sequencer #(
  parameter logic [LFSR_W-1:0] SEED_A = 31'd1,
  parameter logic [LFSR_W-1:0] SEED_B = 31'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_a,
  input  logic [3:0]       op_b,
  input  logic [2:0]       len_sel,
  input  logic             mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LEN_W-1:0] res_count,
  output logic [LEN_W-1:0] res_len,
  output logic             busy
);

  // rst_n is active-high: 1 holds the block in reset.
  logic rst;
  assign rst = rst_n;

  state_t state_q, state_d;

  logic [3:0]       op_a_q, op_b_q;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt_q;
  logic [LEN_W-1:0] ones_q;
  logic [LEN_W-1:0] res_count_q, res_len_q;

  logic accept, seed_load, run_step;
  logic [LFSR_W-1:0] lfsr_a_q, lfsr_b_q;

  sc_lfsr31 #(.RST_VAL(SEED_A)) u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .step (run_step),
    .seed (SEED_A),
    .q    (lfsr_a_q)
  );

  sc_lfsr31 #(.RST_VAL(SEED_B)) u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .step (run_step),
    .seed (SEED_B),
    .q    (lfsr_b_q)
  );

  // Only the top nibble of each LFSR feeds the comparators.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^{lfsr_a_q[TAP_LO-1:0], lfsr_b_q[TAP_LO-1:0]};

  logic             sn_a, sn_b, prod;
  logic [LEN_W-1:0] ones_next;
  logic             last_bit;

  // Stochastic number generation, product gate and running ones count.
  always_comb begin
    sn_a      = (lfsr_a_q[TAP_HI:TAP_LO] < op_a_q);
    sn_b      = (lfsr_b_q[TAP_HI:TAP_LO] < op_b_q);
    prod      = mode_q ? (sn_a & sn_b) : ~(sn_a ^ sn_b);
    ones_next = ones_q + {{(LEN_W-1){1'b0}}, prod};
    last_bit  = (bit_cnt_q == (len_q - 9'd1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and control decode.
  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    accept    = 1'b0;
    seed_load = 1'b0;
    run_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        busy     = 1'b0;
        if (op_valid) begin
          accept  = 1'b1;
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        seed_load = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        run_step = 1'b1;
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Job capture, bit/ones counters and result registers; results only update on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      res_count_q <= '0;
      res_len_q   <= '0;
    end else begin
      if (accept) begin
        op_a_q <= op_a;
        op_b_q <= op_b;
        mode_q <= mode;
        len_q  <= len_decode(len_sel);
      end
      if (seed_load) begin
        bit_cnt_q <= '0;
        ones_q    <= '0;
      end
      if (run_step) begin
        bit_cnt_q <= bit_cnt_q + 9'd1;
        ones_q    <= ones_next;
        if (last_bit) begin
          res_count_q <= ones_next;
          res_len_q   <= len_q;
        end
      end
    end
  end

  assign res_count = res_count_q;
  assign res_len   = res_len_q;

endmodule

// File: tb/tb_sc_mult_sequencer.sv
// tb/tb_sc_mult_sequencer.sv - directed self-checking bench for sc_mult_sequencer
module tb_sc_mult_sequencer;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [2:0] len_sel;
  logic       mode;
  logic       res_valid;
  logic       res_ready;
  logic [8:0] res_count;
  logic [8:0] res_len;
  logic       busy;

  int total;
  int bad;

  sc_mult_sequencer #(
    .SEED_A(31'd1),
    .SEED_B(31'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .len_sel   (len_sel),
    .mode      (mode),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_len   (res_len),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int len_of(input logic [2:0] ls);
    if (ls > 3'd5) return 256;
    return 8 << ls;
  endfunction

  function automatic int model(input logic [3:0] a, input logic [3:0] b, input logic m, input int n);
    logic [30:0] la;
    logic [30:0] lb;
    logic sa, sb, p;
    int c;
    la = 31'd1;
    lb = 31'd2;
    c  = 0;
    for (int k = 0; k < n; k++) begin
      sa = (la[30:27] < a);
      sb = (lb[30:27] < b);
      p  = m ? (sa & sb) : (sa ~^ sb);
      c  = c + int'(p);
      la = {la[29:0], la[27] ^ la[30]};
      lb = {lb[29:0], lb[27] ^ lb[30]};
    end
    return c;
  endfunction

  task automatic start_job(input logic [3:0] a, input logic [3:0] b, input logic m, input logic [2:0] ls);
    @(negedge clk);
    check("accept_ready", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    mode     = m;
    len_sel  = ls;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_a     = 4'($urandom_range(15));
    op_b     = 4'($urandom_range(15));
    mode     = 1'($urandom_range(1));
    len_sel  = 3'($urandom_range(7));
  endtask

  task automatic run_job(input logic [3:0] a, input logic [3:0] b, input logic m, input logic [2:0] ls,
                         output int lat);
    int k;
    start_job(a, b, m, ls);
    k = 0;
    lat = -1;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("res_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("ret_idle", 32'(op_ready), 32'd1);
    check("ret_novalid", 32'(res_valid), 32'd0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [2:0] ls;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    int exp_cnt;
    int n;
    logic seen;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b1;
    op_valid  = 1'b0;
    op_a      = 4'd0;
    op_b      = 4'd0;
    len_sel   = 3'd0;
    mode      = 1'b0;
    res_ready = 1'b0;

    #1;
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_count", 32'(res_count), 32'd0);
    check("rst_len", 32'(res_len), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    run_job(4'd0, 4'd9, 1'b1, 3'd0, lat);
    check("zero_lat", 32'(lat), 32'd10);
    check("zero_count", 32'(res_count), 32'd0);
    check("zero_len", 32'(res_len), 32'd8);
    take_result();

    run_job(4'd0, 4'd0, 1'b0, 3'd7, lat);
    check("full_lat", 32'(lat), 32'd258);
    check("full_count", 32'(res_count), 32'd256);
    check("full_len", 32'(res_len), 32'd256);
    take_result();

    exp_cnt = model(4'd3, 4'd5, 1'b0, 16);
    run_job(4'd3, 4'd5, 1'b0, 3'd1, lat);
    check("hold_lat", 32'(lat), 32'd18);
    for (int i = 0; i < 10; i++) begin
      op_valid = 1'b1;
      op_a     = 4'd15;
      op_b     = 4'd15;
      mode     = 1'b1;
      len_sel  = 3'd0;
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_count", 32'(res_count), 32'(exp_cnt));
      check("hold_len", 32'(res_len), 32'd16);
      check("hold_ready", 32'(op_ready), 32'd0);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("hold_idle", 32'(op_ready), 32'd1);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_novalid", 32'(res_valid), 32'd0);
    check("hold_keep", 32'(res_count), 32'(exp_cnt));

    vecs.push_back('{4'd8,  4'd8,  1'b1, 3'd3});
    vecs.push_back('{4'd15, 4'd1,  1'b0, 3'd2});
    vecs.push_back('{4'd7,  4'd12, 1'b1, 3'd5});
    vecs.push_back('{4'd15, 4'd15, 1'b0, 3'd6});
    vecs.push_back('{4'd4,  4'd11, 1'b0, 3'd4});
    vecs.push_back('{4'd10, 4'd3,  1'b1, 3'd0});
    vecs.push_back('{4'd7,  4'd12, 1'b1, 3'd5});
    vecs.push_back('{4'd0,  4'd0,  1'b1, 3'd2});
    foreach (vecs[i]) begin
      n = len_of(vecs[i].ls);
      run_job(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].ls, lat);
      check("vec_lat", 32'(lat), 32'(n + 2));
      check("vec_count", 32'(res_count), 32'(model(vecs[i].a, vecs[i].b, vecs[i].m, n)));
      check("vec_len", 32'(res_len), 32'(n));
      take_result();
    end

    start_job(4'd5, 4'd6, 1'b0, 3'd3);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", 32'(op_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_count", 32'(res_count), 32'd0);
    check("mid_rst_len", 32'(res_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen = 1'b1;
    end
    check("mid_rst_noresult", 32'(seen), 32'd0);

    run_job(4'd0, 4'd0, 1'b0, 3'd2, lat);
    check("post_rst_lat", 32'(lat), 32'd34);
    check("post_rst_count", 32'(res_count), 32'd32);
    check("post_rst_len", 32'(res_len), 32'd32);
    take_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
